// File: rtl/routelkup_pkg.sv
// Shared types and constants for the routing-lookup arbiter.
package routelkup_pkg;

  localparam int unsigned DEF_MACW = 48;
  localparam int unsigned DEF_NETH = 4;

  localparam logic [DEF_MACW-1:0] BCAST_MAC = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/routelkup_rrsel.sv
// Combinational round-robin selector: first active requester at or after start.
module routelkup_rrsel #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic [NREQ-1:0] grant_oh,
  output logic [IW-1:0]   grant_idx
);

  int unsigned     cand;
  logic [NREQ-1:0] cand_oh;
  logic            found;

  // Walk requesters from start with modulo-NREQ wrap; the first hit wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    cand      = 0;
    cand_oh   = '0;
    found     = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      cand = 32'(start) + 32'(i);
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_oh = NREQ'(1) << cand;
      if (!found && ((req & cand_oh) != '0)) begin
        found     = 1'b1;
        grant_oh  = cand_oh;
        grant_idx = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/routelkup_arbiter.sv
// Round-robin arbiter sharing the routing table's single lookup port.
// Optional watchdog: define ROUTELKUP_WATCHDOG_EN.
module routelkup_arbiter
  import routelkup_pkg::*;
#(
  parameter int unsigned     NREQ         = 4,
  parameter int unsigned     NETH         = DEF_NETH,
  parameter int unsigned     MACW         = DEF_MACW,
  parameter int unsigned     LGWAIT       = 4,
  parameter logic [NETH-1:0] DEFAULT_PORT = {NETH{1'b1}},
  parameter bit              OPT_LOWPOWER = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NREQ-1:0]      REQ_VALID,
  input  logic [NREQ*MACW-1:0] REQ_DSTMAC,
  output logic [NREQ-1:0]      REQ_ACK,
  output logic [NETH-1:0]      REQ_PORT,
  output logic                 REQ_TIMEOUT,
  output logic                 TBL_VALID,
  output logic [MACW-1:0]      TBL_DSTMAC,
  input  logic                 TBL_ACK,
  input  logic [NETH-1:0]      TBL_PORT
);

  localparam int unsigned   IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST_REQ = IW'(NREQ - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic            tbl_valid_q, tbl_valid_d;
  logic [MACW-1:0] tbl_dstmac_q, tbl_dstmac_d;
  logic [NREQ-1:0] req_ack_q, req_ack_d;
  logic [NETH-1:0] req_port_q, req_port_d;

  logic [NREQ-1:0] sel_oh;
  logic [IW-1:0]   sel_idx;
  logic [MACW-1:0] sel_mac;

`ifdef ROUTELKUP_WATCHDOG_EN
  localparam logic [LGWAIT-1:0] WD_LAST = LGWAIT'((32'd1 << LGWAIT) - 32'd2);
  logic [LGWAIT-1:0] wd_q, wd_d;
  logic              req_timeout_q, req_timeout_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(LGWAIT), DEFAULT_PORT};
`endif

  routelkup_rrsel #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rrsel (
    .req       (REQ_VALID),
    .start     (ptr_q),
    .grant_oh  (sel_oh),
    .grant_idx (sel_idx)
  );

  // MAC of the currently selected requester.
  always_comb begin
    sel_mac = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (sel_oh[k]) begin
        sel_mac = REQ_DSTMAC[k*MACW +: MACW];
      end
    end
  end

  // Next-state and next-output logic; TBL_ACK only matters in BUSY.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    tbl_valid_d  = tbl_valid_q;
    tbl_dstmac_d = tbl_dstmac_q;
    req_ack_d    = '0;
    req_port_d   = OPT_LOWPOWER ? '0 : req_port_q;
`ifdef ROUTELKUP_WATCHDOG_EN
    wd_d          = wd_q;
    req_timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sel_oh != '0) begin
          grant_d      = sel_idx;
          ptr_d        = (sel_idx == LAST_REQ) ? '0 : sel_idx + IW'(1);
          tbl_dstmac_d = sel_mac;
          tbl_valid_d  = 1'b1;
          state_d      = BUSY;
`ifdef ROUTELKUP_WATCHDOG_EN
          wd_d         = '0;
`endif
        end
      end
      BUSY: begin
        if (TBL_ACK) begin
          tbl_valid_d  = 1'b0;
          tbl_dstmac_d = OPT_LOWPOWER ? '0 : tbl_dstmac_q;
          req_port_d   = TBL_PORT;
          req_ack_d    = NREQ'(1) << grant_q;
          state_d      = DONE;
        end
`ifdef ROUTELKUP_WATCHDOG_EN
        else if (wd_q == WD_LAST) begin
          tbl_valid_d   = 1'b0;
          tbl_dstmac_d  = OPT_LOWPOWER ? '0 : tbl_dstmac_q;
          req_port_d    = DEFAULT_PORT;
          req_timeout_d = 1'b1;
          req_ack_d     = NREQ'(1) << grant_q;
          state_d       = DONE;
        end else begin
          wd_d = wd_q + LGWAIT'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      tbl_valid_q   <= 1'b0;
      tbl_dstmac_q  <= '0;
      req_ack_q     <= '0;
      req_port_q    <= '0;
`ifdef ROUTELKUP_WATCHDOG_EN
      wd_q          <= '0;
      req_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      tbl_valid_q   <= tbl_valid_d;
      tbl_dstmac_q  <= tbl_dstmac_d;
      req_ack_q     <= req_ack_d;
      req_port_q    <= req_port_d;
`ifdef ROUTELKUP_WATCHDOG_EN
      wd_q          <= wd_d;
      req_timeout_q <= req_timeout_d;
`endif
    end
  end

  assign REQ_ACK    = req_ack_q;
  assign REQ_PORT   = req_port_q;
  assign TBL_VALID  = tbl_valid_q;
  assign TBL_DSTMAC = tbl_dstmac_q;
`ifdef ROUTELKUP_WATCHDOG_EN
  assign REQ_TIMEOUT = req_timeout_q;
`else
  assign REQ_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_routelkup_arbiter.sv
// Directed bench for routelkup_arbiter with a table model and an ack scoreboard.
module tb_routelkup_arbiter;
  import routelkup_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned NETH = 4;
  localparam int unsigned MACW = 48;

  logic                 i_clk = 1'b0;
  logic                 i_reset_n;
  logic [NREQ-1:0]      REQ_VALID;
  logic [NREQ*MACW-1:0] REQ_DSTMAC;
  logic [NREQ-1:0]      REQ_ACK;
  logic [NETH-1:0]      REQ_PORT;
  logic                 REQ_TIMEOUT;
  logic                 TBL_VALID;
  logic [MACW-1:0]      TBL_DSTMAC;
  logic                 TBL_ACK = 1'b0;
  logic [NETH-1:0]      TBL_PORT = '0;

  routelkup_arbiter #(
    .NREQ (NREQ),
    .NETH (NETH),
    .MACW (MACW)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .REQ_VALID   (REQ_VALID),
    .REQ_DSTMAC  (REQ_DSTMAC),
    .REQ_ACK     (REQ_ACK),
    .REQ_PORT    (REQ_PORT),
    .REQ_TIMEOUT (REQ_TIMEOUT),
    .TBL_VALID   (TBL_VALID),
    .TBL_DSTMAC  (TBL_DSTMAC),
    .TBL_ACK     (TBL_ACK),
    .TBL_PORT    (TBL_PORT)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [NREQ-1:0] oh;
    logic [NETH-1:0] port;
    logic            to;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   ack_cnt[NREQ];
  int   tbl_delay = 1;
  bit   tbl_hold  = 1'b0;
  bit   stray_req = 1'b0;
  int   tv_cnt    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Table contents: port bit chosen by the low two bits of the first MAC octet.
  function automatic logic [NETH-1:0] port_of(input logic [MACW-1:0] mac);
    return NETH'(1) << mac[41:40];
  endfunction

  function automatic exp_t mk_exp(input int idx, input logic [NETH-1:0] port, input logic to);
    exp_t e;
    e.oh   = NREQ'(1) << idx;
    e.port = port;
    e.to   = to;
    return e;
  endfunction

  // Table model: acks tbl_delay cycles after TBL_VALID first appears.
  always @(posedge i_clk) begin
    #1;
    if (stray_req) begin
      TBL_ACK   = 1'b1;
      TBL_PORT  = 4'b1010;
      stray_req = 1'b0;
      tv_cnt    = 0;
    end else if (TBL_VALID && !tbl_hold) begin
      tv_cnt++;
      TBL_ACK = (tv_cnt == tbl_delay + 1);
      if (TBL_ACK) TBL_PORT = port_of(TBL_DSTMAC);
    end else begin
      tv_cnt  = 0;
      TBL_ACK = 1'b0;
    end
  end

  // Scoreboard: every REQ_ACK pulse must match the oldest expected result.
  always @(negedge i_clk) begin
    if (i_reset_n === 1'b1 && REQ_ACK !== '0) begin
      exp_t e;
      chk("ack_onehot", 64'($onehot(REQ_ACK)), 64'd1);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 64'(REQ_ACK), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_grant", 64'(REQ_ACK), 64'(e.oh));
        chk("ack_port", 64'(REQ_PORT), 64'(e.port));
        chk("ack_timeout", 64'(REQ_TIMEOUT), 64'(e.to));
      end
      for (int k = 0; k < int'(NREQ); k++) if (REQ_ACK[k]) ack_cnt[k]++;
    end
  end

  task automatic wait_acks(input int n, input int budget, input bit drop);
    int got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge i_clk);
      if (REQ_ACK != '0) begin
        got++;
        if (drop) REQ_VALID = REQ_VALID & ~REQ_ACK;
      end
    end
    chk("ack_count", 64'(got), 64'(n));
  endtask

  task automatic pulse_reset();
    @(negedge i_clk);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  initial begin
    logic [MACW-1:0] m;
    int tv, tack, rack, anyack;

    for (int k = 0; k < int'(NREQ); k++) ack_cnt[k] = 0;
    i_reset_n  = 1'b0;
    REQ_VALID  = '0;
    REQ_DSTMAC = '0;
    repeat (2) @(negedge i_clk);
    chk("rst_req_ack", 64'(REQ_ACK), 64'd0);
    chk("rst_req_port", 64'(REQ_PORT), 64'd0);
    chk("rst_timeout", 64'(REQ_TIMEOUT), 64'd0);
    chk("rst_tbl_valid", 64'(TBL_VALID), 64'd0);
    chk("rst_tbl_mac", 64'(TBL_DSTMAC), 64'd0);
    i_reset_n = 1'b1;
    @(negedge i_clk);

    // Single request from requester 2.
    m = 48'h02_00_00_00_00_05;
    REQ_DSTMAC[2*MACW +: MACW] = m;
    sb.push_back(mk_exp(2, 4'b0100, 1'b0));
    REQ_VALID = 4'b0100;
    for (int c = 1; c <= 2; c++) begin
      @(negedge i_clk);
      chk("t1_tbl_valid", 64'(TBL_VALID), 64'd1);
      chk("t1_tbl_mac", 64'(TBL_DSTMAC), 64'(m));
      chk("t1_no_ack_yet", 64'(REQ_ACK), 64'd0);
    end
    @(negedge i_clk);
    chk("t1_ack_lat", 64'(REQ_ACK), 64'b0100);
    chk("t1_port", 64'(REQ_PORT), 64'b0100);
    chk("t1_valid_drop", 64'(TBL_VALID), 64'd0);
    REQ_VALID = '0;
    repeat (4) @(negedge i_clk);
    chk("t1_port_hold", 64'(REQ_PORT), 64'b0100);
    chk("t1_idle", 64'(TBL_VALID), 64'd0);

    // Fairness: all four requesters held active for 16 lookups.
    pulse_reset();
    for (int k = 0; k < int'(NREQ); k++) begin
      REQ_DSTMAC[k*MACW +: MACW] = {8'(k), 40'h00_0000_0010 + 40'(k)};
      ack_cnt[k] = 0;
    end
    for (int i = 0; i < 16; i++) sb.push_back(mk_exp(i % 4, NETH'(1) << (i % 4), 1'b0));
    REQ_VALID = '1;
    wait_acks(16, 80, 1'b0);
    REQ_VALID = '0;
    @(negedge i_clk);
    for (int k = 0; k < int'(NREQ); k++) chk("t2_fair_count", 64'(ack_cnt[k]), 64'd4);

    // Early withdrawal: requester 1 drops right after its grant.
    sb.push_back(mk_exp(1, 4'b0010, 1'b0));
    sb.push_back(mk_exp(3, 4'b1000, 1'b0));
    REQ_VALID = 4'b1010;
    @(negedge i_clk);
    REQ_VALID[1] = 1'b0;
    wait_acks(2, 20, 1'b1);
    @(negedge i_clk);
    chk("t3_withdrawn_acked", 64'(ack_cnt[1]), 64'd5);

    // Stalled table: ack five cycles late.
    tbl_delay = 5;
    m = REQ_DSTMAC[0 +: MACW];
    sb.push_back(mk_exp(0, port_of(m), 1'b0));
    REQ_VALID = 4'b0001;
    tv = 0; tack = -1; rack = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (TBL_VALID) begin
        tv++;
        chk("t4_mac_stable", 64'(TBL_DSTMAC), 64'(m));
      end
      if (TBL_ACK && tack < 0) tack = c;
      if (REQ_ACK != '0 && rack < 0) begin
        rack = c;
        REQ_VALID = '0;
      end
    end
    chk("t4_valid_len", 64'(tv), 64'd6);
    chk("t4_ack_follow", 64'(rack), 64'(tack + 1));
    tbl_delay = 1;

    // Table never answers.
    tbl_hold = 1'b1;
    REQ_VALID = 4'b0010;
    tv = 0; rack = -1; anyack = 0;
`ifdef ROUTELKUP_WATCHDOG_EN
    sb.push_back(mk_exp(1, 4'b1111, 1'b1));
    for (int c = 0; c < 30; c++) begin
      @(negedge i_clk);
      if (TBL_VALID) tv++;
      if (REQ_ACK != '0 && rack < 0) begin
        rack = c;
        REQ_VALID = '0;
      end
    end
    chk("t5_wd_busy_len", 64'(tv), 64'd15);
    chk("t5_wd_ack_at", 64'(rack), 64'd15);
`else
    for (int c = 0; c < 30; c++) begin
      @(negedge i_clk);
      if (TBL_VALID) tv++;
      if (REQ_ACK != '0) anyack = 1;
    end
    chk("t5_stuck_busy", 64'(tv), 64'd30);
    chk("t5_no_ack", 64'(anyack), 64'd0);
    chk("t5_no_timeout", 64'(REQ_TIMEOUT), 64'd0);
    REQ_VALID = '0;
    pulse_reset();
`endif
    tbl_hold = 1'b0;

    // Reset while BUSY, then a stray ack in IDLE.
    REQ_VALID = 4'b0100;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("t6_busy", 64'(TBL_VALID), 64'd1);
    i_reset_n = 1'b0;
    REQ_VALID = '0;
    @(negedge i_clk);
    chk("t6_rst_ack", 64'(REQ_ACK), 64'd0);
    chk("t6_rst_valid", 64'(TBL_VALID), 64'd0);
    chk("t6_rst_mac", 64'(TBL_DSTMAC), 64'd0);
    chk("t6_rst_port", 64'(REQ_PORT), 64'd0);
    chk("t6_rst_timeout", 64'(REQ_TIMEOUT), 64'd0);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    stray_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      chk("t6_stray_no_ack", 64'(REQ_ACK), 64'd0);
      chk("t6_stray_idle", 64'(TBL_VALID), 64'd0);
    end

    // Normal lookup still works after the stray ack.
    REQ_DSTMAC[3*MACW +: MACW] = BCAST_MAC;
    sb.push_back(mk_exp(3, 4'b1000, 1'b0));
    REQ_VALID = 4'b1000;
    wait_acks(1, 20, 1'b1);
    @(negedge i_clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
